sram_1w1r_tiled: RTL
====================

# sram_1w1r_tiled

Parametrised 1W1R memory wrapper that tiles a grid of FreePDK45 OpenRAM 1w1r macros to any depth, width and mask granularity.
- Adds behaviour the fixed per-memory wrappers lack: a post-reset zero-initialisation sweep, same-cycle read/write collision forwarding, an optional output register and out-of-range address handling.
- Sits between Chisel-generated `*_ext` memory ports (predictor tables, metadata, history buffers) and the hard macros.

## Interface
Parameters:
- `DEPTH`, 256: logical words; must equal `BANKS*MACRO_DEPTH`.
- `WIDTH`, 128: logical word width; must be a multiple of `MACRO_WIDTH`.
- `MACRO_DEPTH`, 128: rows per macro; power of two.
- `MACRO_WIDTH`, 64: bits per macro.
- `MASK_GRAN`, 64: bits per write-mask lane; divides `MACRO_WIDTH`.
- `OUT_REG`, 1: 1 adds a registered output stage.
- `INIT_ZERO`, 1: 1 runs the zero sweep after reset.
- Derived: `AW = clog2(DEPTH)`; `MW = WIDTH/MASK_GRAN`; `BANKS = DEPTH/MACRO_DEPTH`; `COLS = WIDTH/MACRO_WIDTH`.

Ports:
- `clock` in 1: single clock for both ports and all macros.
- `reset_n` in 1: asynchronous, active-low reset.
- `W0_addr` in AW: write address.
- `W0_data` in WIDTH: write data.
- `W0_en` in 1: write enable.
- `W0_mask` in MW: per-lane write enable.
- `R0_addr` in AW: read address.
- `R0_en` in 1: read enable.
- `R0_data` out WIDTH: read data.
- `R0_valid` out 1: `R0_data` holds the result of an accepted read.
- `init_busy` out 1: zero sweep in progress; port requests are ignored.

## Operation
- Bank = `addr[AW-1:clog2(MACRO_DEPTH)]`; row = low bits. Only the selected bank row gets `csb=0`. All `COLS` macros in that bank are accessed together.
- Write: for macro column c, `wmask0` = `W0_mask` lanes `[c*MACRO_WIDTH/MASK_GRAN +: MACRO_WIDTH/MASK_GRAN]`. A write with an all-zero mask still enables the macro and changes nothing.
- Read: bank index, collision lanes and write data are registered alongside the macro access, then used to mux `dout1` in the following cycle.
- Collision (both enables, same address, same cycle): masked lanes of `R0_data` take `W0_data` (write-first). Unmasked lanes take macro output; OpenRAM reads unwritten columns normally.
- Out of range (`addr >= DEPTH`): write is dropped; read returns all-zero with `R0_valid=1`.
- FSM states:
  - `CLEAR`: entered on reset release when `INIT_ZERO=1`. A row counter runs 0..MACRO_DEPTH-1, writing zero with full mask to every bank and column in parallel. Exits to `READY` after row `MACRO_DEPTH-1`.
  - `READY`: normal operation.
- When `INIT_ZERO=0`, reset releases straight to `READY`.
- During `CLEAR`, `W0_en` and `R0_en` are ignored: no macro effect, no `R0_valid`.

## Timing
- Read latency: `R0_valid` pulses `1+OUT_REG` cycles after the `R0_en` edge. One read per cycle, fully pipelined, no backpressure.
- `R0_data` holds its last value when `R0_valid=0` (`OUT_REG=1`). With `OUT_REG=0` it is mux output and don't-care when not valid.
- Write takes effect at the clock edge. A read of the same address in any later cycle sees it.
- Reset values:
  - `R0_valid=0`, `R0_data=0` (registered stage).
  - `init_busy = INIT_ZERO`, row counter 0.
  - Pipeline bank/collision registers 0.
- `init_busy` deasserts on the edge after row `MACRO_DEPTH-1` is written. Sweep length is exactly `MACRO_DEPTH` cycles.
- Reset mid-sweep or mid-read: all valids clear immediately; in-flight reads are lost. The sweep restarts from row 0 on release.
- Memory contents are never reset except by the sweep.

## Test plan
- Default config, release reset: `init_busy` high 128 cycles then low. Read addr 200 -> `R0_valid` 2 cycles later, `R0_data=0`.
- Write `0xA5..A5` full mask to addr 130, read 130 next cycle -> valid 2 cycles after the read, data `0xA5..A5`. Addr 2 still reads 0.
- Collision:
  - Setup: addr 7 holds `A`.
  - Stimulus: same cycle, write `B` mask `2'b01` and read addr 7.
  - Response: `{A[127:64], B[63:0]}`. A subsequent read returns the same value.
- Back-to-back reads 3, 131, 3, 131 with distinct contents -> four consecutive valid cycles, correct bank data in order.
- `DEPTH=192`, `MACRO_DEPTH=64`:
  - Write to addr 250 is dropped and no macro is enabled.
  - Read 250 -> zero, valid.
  - Addr 58 (same row in bank 0) is unchanged.
- Assert `reset_n` low at sweep cycle 40 for 2 cycles: outputs return to reset values, then `init_busy` stays high a full 128 cycles after release. `R0_en` during that window yields no `R0_valid`.

Source files
------------

// File: rtl/sram_1w1r_tiled.sv
// sram_1w1r_tiled
//   Parametrised 1W1R memory built from a BANKS x COLS grid of 1w1r macro
//   tiles. Adds a post-reset zero sweep, same-cycle write-to-read forwarding
//   (write-first), an optional output register and out-of-range handling.
//
// Ports
//   clock      : single clock for both ports and every tile
//   reset_n    : asynchronous active-low reset
//   W0_addr    : write address (AW bits)
//   W0_data    : write data (WIDTH bits)
//   W0_en      : write enable
//   W0_mask    : per-lane write enable, one bit per MASK_GRAN bits
//   R0_addr    : read address (AW bits)
//   R0_en      : read enable
//   R0_data    : read data, valid when R0_valid is high
//   R0_valid   : R0_data holds the result of an accepted read
//   init_busy  : zero sweep in progress; port requests are ignored
//
// Each tile is a set of per-lane arrays with the macro's port behaviour:
// a masked synchronous write port and a chip-selected read port whose
// output holds its value between reads.
module sram_1w1r_tiled #(
  parameter int DEPTH       = 256,
  parameter int WIDTH       = 128,
  parameter int MACRO_DEPTH = 128,
  parameter int MACRO_WIDTH = 64,
  parameter int MASK_GRAN   = 64,
  parameter int OUT_REG     = 1,
  parameter int INIT_ZERO   = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int MW = WIDTH / MASK_GRAN
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [AW-1:0]    W0_addr,
  input  logic [WIDTH-1:0] W0_data,
  input  logic             W0_en,
  input  logic [MW-1:0]    W0_mask,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  output logic             init_busy
);

  localparam int BANKS = DEPTH / MACRO_DEPTH;
  localparam int COLS  = WIDTH / MACRO_WIDTH;
  localparam int RW    = $clog2(MACRO_DEPTH);
  localparam int LPM   = MACRO_WIDTH / MASK_GRAN;  // mask lanes per macro
  localparam int BW    = (AW > RW) ? AW - RW : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // ---------------- address decode ----------------
  logic [RW-1:0] w_row, r_row;
  logic [BW-1:0] w_bank, r_bank;
  logic          w_in_range, r_in_range;

  assign w_row      = W0_addr[RW-1:0];
  assign r_row      = R0_addr[RW-1:0];
  assign w_in_range = ({1'b0, W0_addr} < DEPTH_L);
  assign r_in_range = ({1'b0, R0_addr} < DEPTH_L);

  if (AW > RW) begin : g_bank_sel
    assign w_bank = W0_addr[AW-1:RW];
    assign r_bank = R0_addr[AW-1:RW];
  end else begin : g_single_bank
    assign w_bank = '0;
    assign r_bank = '0;
  end

  // ---------------- sweep FSM ----------------
  logic [0:0]    state_reg, state_next;
  logic [RW-1:0] row_cnt_reg, row_cnt_next;

  always_comb begin
    state_next   = state_reg;
    row_cnt_next = row_cnt_reg;
    if (state_reg == ST_CLEAR) begin
      row_cnt_next = row_cnt_reg + RW'(1);
      if (row_cnt_reg == RW'(MACRO_DEPTH - 1)) begin
        state_next   = ST_READY;
        row_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= (INIT_ZERO != 0) ? ST_CLEAR : ST_READY;
      row_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      row_cnt_reg <= row_cnt_next;
    end
  end

  assign init_busy = (state_reg == ST_CLEAR);

  // Tiles are untouched while reset is held so contents survive a reset
  // except through the sweep that follows it.
  logic ready, sweep_we, port_we, port_rd, port_re, collision;
  assign ready     = reset_n & (state_reg == ST_READY);
  assign sweep_we  = reset_n & (state_reg == ST_CLEAR);
  assign port_we   = ready & W0_en & w_in_range;
  assign port_rd   = ready & R0_en;
  assign port_re   = port_rd & r_in_range;
  assign collision = port_we & port_rd & (W0_addr == R0_addr);

  // Shared write-port signals: the sweep writes zeros, full mask, to the
  // same row of every tile at once.
  logic [RW-1:0]    mem_wrow;
  logic [WIDTH-1:0] mem_wdata;
  logic [MW-1:0]    mem_wmask;
  assign mem_wrow  = sweep_we ? row_cnt_reg : w_row;
  assign mem_wdata = sweep_we ? '0 : W0_data;
  assign mem_wmask = sweep_we ? '1 : W0_mask;

  // ---------------- tile grid ----------------
  logic [BANKS-1:0][WIDTH-1:0] bank_dout;

  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    logic bank_we, bank_re;
    assign bank_we = sweep_we | (port_we & (w_bank == BW'(gi)));
    assign bank_re = port_re & (r_bank == BW'(gi));

    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      logic [LPM-1:0] wmask0;
      assign wmask0 = mem_wmask[gc*LPM +: LPM];

      for (genvar gl = 0; gl < LPM; gl++) begin : g_lane
        localparam int LANE = gc*LPM + gl;
        logic [MASK_GRAN-1:0] mem [MACRO_DEPTH];
        logic [MASK_GRAN-1:0] dout_reg;

        // A write with the lane masked off leaves the row untouched; the
        // read port returns pre-write contents for a same-row access.
        always_ff @(posedge clock) begin
          if (bank_we && wmask0[gl])
            mem[mem_wrow] <= mem_wdata[LANE*MASK_GRAN +: MASK_GRAN];
          if (bank_re)
            dout_reg <= mem[r_row];
        end

        assign bank_dout[gi][LANE*MASK_GRAN +: MASK_GRAN] = dout_reg;
      end
    end
  end

  // ---------------- read pipeline, stage 1 ----------------
  logic             s1_valid_reg;
  logic             s1_oor_reg;
  logic [BW-1:0]    s1_bank_reg;
  logic [MW-1:0]    s1_coll_reg;
  logic [WIDTH-1:0] s1_wdata_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_oor_reg   <= 1'b0;
      s1_bank_reg  <= '0;
      s1_coll_reg  <= '0;
      s1_wdata_reg <= '0;
    end else begin
      s1_valid_reg <= port_rd;
      if (port_rd) begin
        s1_oor_reg   <= ~r_in_range;
        s1_bank_reg  <= r_bank;
        s1_coll_reg  <= collision ? W0_mask : '0;
        s1_wdata_reg <= W0_data;
      end
    end
  end

  // Pick the bank captured with the read, then overlay forwarded lanes.
  logic [WIDTH-1:0] sel_dout, mux_data;
  always_comb begin
    sel_dout = '0;
    for (int b = 0; b < BANKS; b++)
      if (s1_bank_reg == BW'(b)) sel_dout = bank_dout[b];
    mux_data = '0;
    if (!s1_oor_reg)
      for (int l = 0; l < MW; l++)
        mux_data[l*MASK_GRAN +: MASK_GRAN] = s1_coll_reg[l]
            ? s1_wdata_reg[l*MASK_GRAN +: MASK_GRAN]
            : sel_dout[l*MASK_GRAN +: MASK_GRAN];
  end

  // ---------------- optional output stage ----------------
  if (OUT_REG != 0) begin : g_out_reg
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        out_valid_reg <= 1'b0;
        out_data_reg  <= '0;
      end else begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) out_data_reg <= mux_data;
      end
    end
    assign R0_valid = out_valid_reg;
    assign R0_data  = out_data_reg;
  end else begin : g_out_comb
    assign R0_valid = s1_valid_reg;
    assign R0_data  = mux_data;
  end

endmodule
